// File: rtl/fire_alarm_pkg.sv
// Shared definitions for the fire alarm controller: state codes and
// default timing constants (all timing values are in 1 kHz clock cycles).
package fire_alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CONFIRM  = 2'd1,
    ST_ALARM    = 2'd2,
    ST_SILENCED = 2'd3
  } state_t;

  localparam int CONFIRM_MS_DEF = 50;
  localparam int BEEP_HALF_DEF  = 250;
  localparam int SILENCE_MS_DEF = 10000;
  localparam int CNT_W_DEF      = 14;

endpackage

// File: rtl/fire_alarm_ctrl_beep_gen.sv
// Square-wave pattern generator shared by the buzzer and the LED blink.
// Q restarts high on RESTART, toggles every BEEP_HALF enabled cycles and
// is held low while disabled.
module beep_gen
  import fire_alarm_pkg::*;
#(
  parameter int BEEP_HALF = BEEP_HALF_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic CLK1K,
  input  logic RST,
  input  logic EN,
  input  logic RESTART,
  output logic Q
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BEEP_HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_q;

  // Half-period counter and toggle; restart takes effect on the same edge
  // the controller enters a pattern-driving state.
  always_ff @(posedge CLK1K or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (!EN) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (RESTART) begin
      r_cnt <= '0;
      r_q   <= 1'b1;
    end else if (r_cnt == HALF_LAST) begin
      r_cnt <= '0;
      r_q   <= ~r_q;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/fire_alarm_ctrl.sv
// Latching fire alarm controller: confirms a sustained detection, latches
// the alarm, pulses the buzzer, and handles operator silence and clear.
module fire_alarm_ctrl
  import fire_alarm_pkg::*;
#(
  parameter int CONFIRM_MS = CONFIRM_MS_DEF,
  parameter int BEEP_HALF  = BEEP_HALF_DEF,
  parameter int SILENCE_MS = SILENCE_MS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       CLK1K,
  input  logic       RST,
  input  logic       FIRE_ALARM,
  input  logic       ACK,
  input  logic       CLEAR,
  output logic       BUZZER,
  output logic       LED,
  output logic       ALARM_ACTIVE,
  output logic [1:0] STATE
);

  localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(CONFIRM_MS - 1);
  localparam logic [CNT_W-1:0] SIL_LAST  = CNT_W'(SILENCE_MS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_conf_cnt;
  logic [CNT_W-1:0] r_sil_cnt;
  logic             r_ack_d;
  logic             r_alarm_active;
  logic             w_ack_rise;
  logic             w_clear_ok;
  logic             w_beep_en;
  logic             w_beep_restart;
  logic             w_beep_q;

  assign w_ack_rise = ACK & ~r_ack_d;
  // Clearing is only honoured once the detector has dropped.
  assign w_clear_ok = CLEAR & ~FIRE_ALARM;

  // Next-state decision; priority is clear, then ack rise, then timer expiry.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (FIRE_ALARM) w_state_next = ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (!FIRE_ALARM)              w_state_next = ST_IDLE;
        else if (r_conf_cnt == CONF_LAST) w_state_next = ST_ALARM;
      end
      ST_ALARM: begin
        if (w_clear_ok)      w_state_next = ST_IDLE;
        else if (w_ack_rise) w_state_next = ST_SILENCED;
      end
      ST_SILENCED: begin
        if (w_clear_ok)                                   w_state_next = ST_IDLE;
        else if (!w_ack_rise && (r_sil_cnt == SIL_LAST))  w_state_next = ST_ALARM;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The pattern generator runs in the latched states and restarts high on
  // every entry into either of them.
  assign w_beep_en      = (w_state_next == ST_ALARM) || (w_state_next == ST_SILENCED);
  assign w_beep_restart = w_beep_en && (w_state_next != r_state);

  // FSM state, counters, ack edge history and registered alarm flag.
  always_ff @(posedge CLK1K or posedge RST) begin
    if (RST) begin
      r_state        <= ST_IDLE;
      r_conf_cnt     <= '0;
      r_sil_cnt      <= '0;
      r_ack_d        <= 1'b1;
      r_alarm_active <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_ack_d        <= ACK;
      r_alarm_active <= w_beep_en;

      // The IDLE sample counts as the first confirming sample.
      if ((r_state == ST_CONFIRM) && (w_state_next == ST_CONFIRM))
        r_conf_cnt <= r_conf_cnt + CNT_W'(1);
      else if (w_state_next == ST_CONFIRM)
        r_conf_cnt <= CNT_W'(1);
      else
        r_conf_cnt <= '0;

      // A fresh ack rise while silenced restarts the silence window.
      if ((r_state == ST_SILENCED) && (w_state_next == ST_SILENCED) && !w_ack_rise)
        r_sil_cnt <= r_sil_cnt + CNT_W'(1);
      else
        r_sil_cnt <= '0;
    end
  end

  beep_gen #(
    .BEEP_HALF (BEEP_HALF),
    .CNT_W     (CNT_W)
  ) u_beep_gen (
    .CLK1K   (CLK1K),
    .RST     (RST),
    .EN      (w_beep_en),
    .RESTART (w_beep_restart),
    .Q       (w_beep_q)
  );

  // Outputs depend only on registers, never on inputs directly.
  assign STATE        = r_state;
  assign ALARM_ACTIVE = r_alarm_active;
  assign BUZZER       = (r_state == ST_ALARM) & w_beep_q;
  assign LED          = (r_state == ST_ALARM) | ((r_state == ST_SILENCED) & w_beep_q);

endmodule

// File: tb/tb_fire_alarm_ctrl.sv
// Bench for fire_alarm_ctrl: directed scenarios with literal expectations
// plus a randomized run, all compared every cycle to a behavioural model.
module tb_fire_alarm_ctrl;

  localparam int CM = 4;
  localparam int BH = 3;
  localparam int SM = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       fire, ack, clear;
  logic       BUZZER, LED, ALARM_ACTIVE;
  logic [1:0] STATE;

  int checks = 0;
  int passes = 0;

  fire_alarm_ctrl #(
    .CONFIRM_MS (CM),
    .BEEP_HALF  (BH),
    .SILENCE_MS (SM),
    .CNT_W      (14)
  ) dut (
    .CLK1K        (clk),
    .RST          (rst),
    .FIRE_ALARM   (fire),
    .ACK          (ack),
    .CLEAR        (clear),
    .BUZZER       (BUZZER),
    .LED          (LED),
    .ALARM_ACTIVE (ALARM_ACTIVE),
    .STATE        (STATE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Alarm is "latched" once CM consecutive high samples are seen; the
  // pattern phase is measured in edges since entering alarm/silence.
  int  cyc = 0;
  int  m_run = 0;
  bit  m_lat = 0, m_sil = 0, m_ackp = 1, m_rise, m_blink;
  int  m_phase = 0, m_dead = 0;
  int  e_state;
  bit  e_buz, e_led;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_run = 0; m_lat = 0; m_sil = 0; m_ackp = 1;
    end else begin
      m_rise = ack && !m_ackp;
      m_ackp = ack;
      if (!m_lat) begin
        if (fire) begin
          m_run = m_run + 1;
          if (m_run == CM) begin
            m_lat = 1; m_sil = 0; m_phase = cyc; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end else if (clear && !fire) begin
        m_lat = 0; m_sil = 0;
      end else if (m_rise) begin
        if (!m_sil) begin
          m_sil = 1; m_phase = cyc;
        end
        m_dead = cyc + SM;
      end else if (m_sil && cyc == m_dead) begin
        m_sil = 0; m_phase = cyc;
      end
    end
    #1;
    m_blink = (((cyc - m_phase) / BH) % 2) == 0;
    e_state = m_lat ? (m_sil ? 3 : 2) : (m_run > 0 ? 1 : 0);
    e_buz   = m_lat && !m_sil && m_blink;
    e_led   = m_lat && (!m_sil || m_blink);
    chk("model_state",  32'(STATE),        32'(e_state));
    chk("model_buzzer", 32'(BUZZER),       32'(e_buz));
    chk("model_led",    32'(LED),          32'(e_led));
    chk("model_active", 32'(ALARM_ACTIVE), 32'(m_lat));
  end

  // Apply inputs mid-cycle, then return just after the next rising edge.
  task automatic drive(input bit f, input bit a, input bit c);
    fire = f; ack = a; clear = c;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_state"},  32'(STATE),        32'd0);
    chk({name, "_buzzer"}, 32'(BUZZER),       32'd0);
    chk({name, "_led"},    32'(LED),          32'd0);
    chk({name, "_active"}, 32'(ALARM_ACTIVE), 32'd0);
  endtask

  // Assert reset between edges, confirm outputs clear at once, release
  // after one rising edge has seen it.
  task automatic async_reset(input string name);
    #1 rst = 1'b1;
    #1 chk_zero(name);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  int exp_st1[8]  = '{1, 1, 1, 0, 1, 1, 1, 2};
  int exp_buz1[6] = '{1, 1, 0, 0, 0, 1};
  int exp_led3[9] = '{1, 1, 0, 0, 0, 1, 1, 1, 0};
  bit f_pat[8]    = '{1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    int n_sil;
    logic [1:0] prev;
    bit f_r, a_r, c_r;

    rst = 1'b1; fire = 0; ack = 0; clear = 0;
    #3 chk_zero("reset");
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;

    // 1: glitch rejection and buzzer pattern
    for (int i = 0; i < 8; i++) begin
      drive(f_pat[i], 0, 0);
      chk("glitch_state", 32'(STATE), 32'(exp_st1[i]));
    end
    chk("alarm_buzzer_entry", 32'(BUZZER), 32'd1);
    chk("alarm_led_entry",    32'(LED),    32'd1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0);
      chk("buzzer_pattern", 32'(BUZZER), 32'(exp_buz1[i]));
    end

    // 2: latch and clear
    drive(0, 0, 0); drive(0, 0, 0);
    chk("latched_fire_low", 32'(STATE), 32'd2);
    drive(1, 0, 1);
    chk("clear_ignored", 32'(STATE), 32'd2);
    drive(0, 0, 1);
    chk_zero("cleared");
    drive(0, 0, 0);

    // 3: silence and re-arm
    for (int i = 0; i < CM; i++) drive(1, 0, 0);
    chk("reach_alarm", 32'(STATE), 32'd2);
    drive(1, 1, 0);
    chk("silenced_state",  32'(STATE),  32'd3);
    chk("silenced_buzzer", 32'(BUZZER), 32'd0);
    chk("silenced_led",    32'(LED),    32'd1);
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0);
      chk("silence_hold", 32'(STATE), 32'd3);
      chk("silence_blink", 32'(LED), 32'(exp_led3[i]));
    end
    drive(0, 0, 0);
    chk("rearm_state",  32'(STATE),  32'd2);
    chk("rearm_buzzer", 32'(BUZZER), 32'd1);

    // 4a: ack held high causes a single silence
    n_sil = 0;
    prev = STATE;
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0);
      if (prev == 2'd2 && STATE == 2'd3) n_sil++;
      prev = STATE;
    end
    chk("ack_held_transitions", 32'(n_sil), 32'd1);
    chk("ack_held_end_state",   32'(STATE), 32'd2);
    // 4b: second rise at silence cycle 8 pushes the re-arm out
    drive(0, 0, 0); drive(0, 0, 0);
    drive(0, 1, 0);
    chk("ack_pulse_silence", 32'(STATE), 32'd3);
    for (int i = 0; i < 7; i++) drive(0, 0, 0);
    drive(0, 1, 0);
    for (int i = 0; i < 9; i++) drive(0, 0, 0);
    chk("rearm_delayed_hold", 32'(STATE), 32'd3);
    drive(0, 0, 0);
    chk("rearm_delayed", 32'(STATE), 32'd2);

    // 5: clear beats ack rise
    drive(0, 0, 0);
    drive(0, 1, 1);
    chk("clear_over_ack", 32'(STATE), 32'd0);
    drive(0, 0, 0);

    // 6a: reset mid-alarm and mid-confirm
    for (int i = 0; i < CM + 2; i++) drive(1, 0, 0);
    chk("pre_reset_alarm", 32'(STATE), 32'd2);
    async_reset("rst_in_alarm");
    drive(1, 0, 0); drive(1, 0, 0);
    chk("pre_reset_confirm", 32'(STATE), 32'd1);
    async_reset("rst_in_confirm");
    drive(0, 0, 0);

    // 6b: ack held through reset release gives no rise
    drive(0, 1, 0);
    async_reset("rst_ack_held");
    for (int i = 0; i < CM; i++) drive(1, 1, 0);
    chk("ackheld_alarm", 32'(STATE), 32'd2);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0);
      chk("ackheld_no_silence", 32'(STATE), 32'd2);
    end
    drive(1, 0, 0);
    drive(1, 1, 0);
    chk("ack_toggle_silence", 32'(STATE), 32'd3);
    drive(0, 0, 1);
    chk("final_clear", 32'(STATE), 32'd0);

    // randomized run against the model
    f_r = 0; a_r = 0; c_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) f_r = !f_r;
      if ($urandom_range(5) == 0) a_r = !a_r;
      c_r = ($urandom_range(14) == 0);
      if ($urandom_range(199) == 0) begin
        rst = 1'b1;
        #1 chk_zero("rand_rst");
      end
      drive(f_r, a_r, c_r);
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
